// File: rtl/alu_ctrl_fsm_pkg.sv
// alu_ctrl_fsm_pkg: shared types and constants for the ALU control sequencer.
// Holds state/class encodings, opcode/funct codes, ALU op selects and the branch test.
package alu_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_JMP
  } cls_e;

  localparam logic [2:0] OPC_R   = 3'b000;
  localparam logic [2:0] OPC_I   = 3'b001;
  localparam logic [2:0] OPC_MEM = 3'b010;
  localparam logic [2:0] OPC_BR  = 3'b011;
  localparam logic [2:0] OPC_JMP = 3'b100;

  localparam logic [3:0] FN_ADD   = 4'b0001;
  localparam logic [3:0] FN_COMP  = 4'b0010;
  localparam logic [3:0] FN_AND   = 4'b0011;
  localparam logic [3:0] FN_XOR   = 4'b0100;
  localparam logic [3:0] FN_SHLL  = 4'b0101;
  localparam logic [3:0] FN_SHRL  = 4'b0110;
  localparam logic [3:0] FN_SHRA  = 4'b0111;
  localparam logic [3:0] FN_LOAD  = 4'b0000;
  localparam logic [3:0] FN_STORE = 4'b0001;
  localparam logic [3:0] FN_JMP   = 4'b0000;
  localparam logic [3:0] FN_BRMAX = 4'b0101;

  localparam logic [4:0] ALU_PASS  = 5'b00000;
  localparam logic [4:0] ALU_ADD   = 5'b00001;
  localparam logic [4:0] ALU_ADDNC = 5'b00101;
  localparam logic [4:0] ALU_ADDR  = 5'b10101;
  localparam logic [4:0] ALU_AND   = 5'b00010;
  localparam logic [4:0] ALU_XOR   = 5'b00011;
  localparam logic [4:0] ALU_SHLL  = 5'b01000;
  localparam logic [4:0] ALU_SHRL  = 5'b01010;
  localparam logic [4:0] ALU_SHRA  = 5'b01011;

  // cond: 0 bz, 1 bnz, 2 bltz, 3 bgez, 4 bcy, 5 bncy
  function automatic logic br_cond(
    input logic [2:0] cond,
    input logic       z,
    input logic       s,
    input logic       c
  );
    logic t;
    unique case (cond[2:1])
      2'b00:   t = z;
      2'b01:   t = s;
      default: t = c;
    endcase
    return cond[0] ? ~t : t;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational (opcode, funct) -> alu_op, alu_sel, class, illegal.
// Undefined combinations raise illegal with a pass-through op.
module alu_ctrl_decode
  import alu_ctrl_fsm_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [3:0] funct,
  output logic [4:0] alu_op,
  output logic       alu_sel,
  output cls_e       cls,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_PASS;
    alu_sel = 1'b0;
    cls     = CLS_R;
    illegal = 1'b0;
    unique case (opcode)
      OPC_R: begin
        cls = CLS_R;
        unique case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_COMP: begin
            alu_op  = ALU_ADDNC;
            alu_sel = 1'b1;
          end
          FN_AND:  alu_op = ALU_AND;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SHLL: alu_op = ALU_SHLL;
          FN_SHRL: alu_op = ALU_SHRL;
          FN_SHRA: alu_op = ALU_SHRA;
          default: illegal = 1'b1;
        endcase
      end
      OPC_I: begin
        cls = CLS_I;
        unique case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_COMP: begin
            alu_op  = ALU_ADDNC;
            alu_sel = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_MEM: begin
        alu_op = ALU_ADDR;
        unique case (funct)
          FN_LOAD:  cls = CLS_LD;
          FN_STORE: cls = CLS_ST;
          default:  illegal = 1'b1;
        endcase
      end
      OPC_BR: begin
        cls     = CLS_BR;
        illegal = (funct > FN_BRMAX);
      end
      OPC_JMP: begin
        cls     = CLS_JMP;
        illegal = (funct != FN_JMP);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_op  = ALU_PASS;
      alu_sel = 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle sequencer IDLE->DECODE->EXEC->(MEM)->WB driving ALU selects,
// holding the C/Z/S flag register and emitting writeback/branch/done strobes.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] opcode,
  input  logic [3:0] funct,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic       mem_ack,
  output logic [4:0] alu_op,
  output logic       alu_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       branch_taken,
  output logic       done,
  output logic       illegal,
  output logic       mem_error,
  output logic       busy,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_s
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state;
  cls_e             cls_q;
  logic [2:0]       op_q;
  logic [3:0]       fn_q;
  logic [CNT_W-1:0] cnt;

  logic [4:0] dec_op;
  logic       dec_sel;
  cls_e       dec_cls;
  logic       dec_ill;

  alu_ctrl_decode u_dec (
    .opcode  (op_q),
    .funct   (fn_q),
    .alu_op  (dec_op),
    .alu_sel (dec_sel),
    .cls     (dec_cls),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cls_q        <= CLS_R;
      op_q         <= '0;
      fn_q         <= '0;
      cnt          <= '0;
      instr_ready  <= 1'b1;
      busy         <= 1'b0;
      alu_op       <= ALU_PASS;
      alu_sel      <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      mem_error    <= 1'b0;
      flag_c       <= 1'b0;
      flag_z       <= 1'b0;
      flag_s       <= 1'b0;
    end else begin
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      mem_error    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q        <= opcode;
            fn_q        <= funct;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_ill) begin
            done    <= 1'b1;
            illegal <= 1'b1;
            state   <= S_WB;
          end else begin
            alu_op  <= dec_op;
            alu_sel <= dec_sel;
            cls_q   <= dec_cls;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_op  <= ALU_PASS;
          alu_sel <= 1'b0;
          flag_z  <= alu_zero;
          flag_s  <= alu_sign;
          if (alu_op == ALU_ADD) flag_c <= alu_carry;
          if (cls_q == CLS_LD || cls_q == CLS_ST) begin
            mem_read  <= (cls_q == CLS_LD);
            mem_write <= (cls_q == CLS_ST);
            cnt       <= '0;
            state     <= S_MEM;
          end else begin
            done         <= 1'b1;
            reg_write    <= (cls_q == CLS_R || cls_q == CLS_I);
            // bcy/bncy test the flag as it stood before this instruction
            branch_taken <= (cls_q == CLS_JMP) ||
                            (cls_q == CLS_BR &&
                             br_cond(fn_q[2:0], alu_zero, alu_sign, flag_c));
            state        <= S_WB;
          end
        end
        S_MEM: begin
          cnt <= cnt + CNT_W'(1);
          // ack wins over timeout in the final wait cycle
          if (mem_ack || cnt == CNT_LAST) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= 1'b1;
            reg_write <= mem_ack && (cls_q == CLS_LD);
            mem_error <= ~mem_ack;
            state     <= S_WB;
          end
        end
        S_WB: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: directed + random instruction stream checked cycle by cycle
// against an instruction-level reference model of the sequencer.
module tb_alu_ctrl_fsm;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [3:0] funct;
  logic       alu_carry, alu_zero, alu_sign, mem_ack;
  logic [4:0] alu_op;
  logic       alu_sel, mem_read, mem_write, reg_write;
  logic       branch_taken, done, illegal, mem_error, busy;
  logic       flag_c, flag_z, flag_s;

  int checks   = 0;
  int failures = 0;

  bit m_c, m_z, m_s;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .funct        (funct),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_sign     (alu_sign),
    .mem_ack      (mem_ack),
    .alu_op       (alu_op),
    .alu_sel      (alu_sel),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .branch_taken (branch_taken),
    .done         (done),
    .illegal      (illegal),
    .mem_error    (mem_error),
    .busy         (busy),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .flag_s       (flag_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // kind: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 jump, -1 illegal
  task automatic ref_dec(input int op, input int fn, output int kind,
                         output int aop, output int asel);
    kind = -1; aop = 0; asel = 0;
    if (op == 0) begin
      case (fn)
        1: begin kind = 0; aop = 5'b00001; end
        2: begin kind = 0; aop = 5'b00101; asel = 1; end
        3: begin kind = 0; aop = 5'b00010; end
        4: begin kind = 0; aop = 5'b00011; end
        5: begin kind = 0; aop = 5'b01000; end
        6: begin kind = 0; aop = 5'b01010; end
        7: begin kind = 0; aop = 5'b01011; end
        default: kind = -1;
      endcase
    end else if (op == 1 && fn == 1) begin
      kind = 1; aop = 5'b00001;
    end else if (op == 1 && fn == 2) begin
      kind = 1; aop = 5'b00101; asel = 1;
    end else if (op == 2 && fn < 2) begin
      kind = 2 + fn; aop = 5'b10101;
    end else if (op == 3 && fn <= 5) begin
      kind = 4;
    end else if (op == 4 && fn == 0) begin
      kind = 5;
    end
  endtask

  function automatic bit ref_taken(input int fn, input bit z, input bit s, input bit c);
    case (fn)
      0: return z;
      1: return !z;
      2: return s;
      3: return !s;
      4: return c;
      default: return !c;
    endcase
  endfunction

  // ack_at: MEM cycle (1-based) in which mem_ack is high; 0 or > TO means never
  task automatic run(input string nm, input int op, input int fn,
                     input bit c_in, input bit z_in, input bit s_in, input int ack_at);
    int kind, aop, asel, n, dc;
    bit ismem, acked, exp_rw, exp_bt;
    ref_dec(op, fn, kind, aop, asel);
    ismem = (kind == 2 || kind == 3);
    acked = ismem && ack_at >= 1 && ack_at <= TO;
    n     = acked ? ack_at : TO;
    dc    = (kind < 0) ? 2 : (ismem ? 3 + n : 3);
    exp_rw = (kind == 0 || kind == 1 || (kind == 2 && acked));
    exp_bt = (kind == 5) || (kind == 4 && ref_taken(fn, z_in, s_in, m_c));

    @(negedge clk);
    chk({nm, ".ready"}, instr_ready, 1);
    chk({nm, ".idle_busy"}, busy, 0);
    chk({nm, ".fc"}, flag_c, m_c);
    chk({nm, ".fz"}, flag_z, m_z);
    chk({nm, ".fs"}, flag_s, m_s);
    instr_valid = 1'b1;
    opcode      = 3'(op);
    funct       = 4'(fn);
    alu_carry   = c_in;
    alu_zero    = z_in;
    alu_sign    = s_in;
    mem_ack     = 1'b0;

    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      instr_valid = ($urandom_range(0, 1) == 1);
      opcode      = 3'($urandom);
      funct       = 4'($urandom);
      chk({nm, ".aluop"}, alu_op, (c == 2 && kind >= 0) ? aop : 0);
      chk({nm, ".alusel"}, alu_sel, (c == 2 && kind >= 0) ? asel : 0);
      chk({nm, ".mrd"}, mem_read, (kind == 2 && c >= 3 && c < dc) ? 1 : 0);
      chk({nm, ".mwr"}, mem_write, (kind == 3 && c >= 3 && c < dc) ? 1 : 0);
      chk({nm, ".done"}, done, (c == dc) ? 1 : 0);
      chk({nm, ".rw"}, reg_write, (c == dc) ? exp_rw : 0);
      chk({nm, ".bt"}, branch_taken, (c == dc) ? exp_bt : 0);
      chk({nm, ".ill"}, illegal, (c == dc && kind < 0) ? 1 : 0);
      chk({nm, ".merr"}, mem_error, (c == dc && ismem && !acked) ? 1 : 0);
      chk({nm, ".busy"}, busy, 1);
      chk({nm, ".nrdy"}, instr_ready, 0);
      mem_ack = ismem && acked && (c == 2 + ack_at);
    end
    mem_ack     = 1'b0;
    instr_valid = 1'b0;

    if (kind >= 0) begin
      m_z = z_in;
      m_s = s_in;
      if (aop == 1) m_c = c_in;
    end
  endtask

  task automatic abort_in_exec();
    @(negedge clk);
    chk("abort.ready", instr_ready, 1);
    instr_valid = 1'b1;
    opcode = 3'd0; funct = 4'd1;
    alu_carry = 1'b1; alu_zero = 1'b1; alu_sign = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort.exec_op", alu_op, 5'b00001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_c = 0; m_z = 0; m_s = 0;
    for (int c = 0; c < 3; c++) begin
      chk("abort.done", done, 0);
      chk("abort.rw", reg_write, 0);
      chk("abort.aluop", alu_op, 0);
      chk("abort.busy", busy, 0);
      chk("abort.ready", instr_ready, 1);
      chk("abort.fc", flag_c, 0);
      chk("abort.fz", flag_z, 0);
      chk("abort.fs", flag_s, 0);
      if (c < 2) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, fn;
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = '0; funct = '0;
    alu_carry = 0; alu_zero = 0; alu_sign = 0; mem_ack = 0;
    m_c = 0; m_z = 0; m_s = 0;
    repeat (2) @(negedge clk);
    chk("rst.ready", instr_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.aluop", alu_op, 0);
    chk("rst.strobes", {done, reg_write, branch_taken, illegal, mem_error}, 0);
    chk("rst.mem", {mem_read, mem_write}, 0);
    chk("rst.flags", {flag_c, flag_z, flag_s}, 0);
    rst = 1'b0;

    run("add", 0, 1, 1, 1, 0, 0);
    run("comp", 0, 2, 0, 0, 1, 0);
    run("load", 2, 0, 0, 0, 0, 3);
    run("store_to", 3 - 1, 1, 0, 1, 0, 0);
    run("bz", 3, 0, 0, 1, 0, 0);
    run("addclr", 0, 1, 0, 0, 0, 0);
    run("bcy", 3, 4, 1, 0, 0, 0);
    run("ill111", 7, 0, 1, 1, 1, 0);
    run("load_edge", 2, 0, 1, 0, 1, TO);
    run("store_ack1", 2, 1, 0, 0, 0, 1);
    run("jmp", 4, 0, 0, 0, 0, 0);
    run("badfn", 0, 0, 0, 0, 0, 0);
    abort_in_exec();
    run("postrst", 1, 1, 1, 0, 1, 0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 7);
      fn = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 15);
      run("rnd", op, fn, 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, TO + 1));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle control sequencer that drives the datapath ALU's operation select (alu_op, alu_sel) and consumes its status outputs (carry, zero, sign).
- Accepts one decoded instruction through a valid/ready handshake and steps it through decode, execute, optional memory wait and writeback.
- Holds the architectural flag register, resolves conditional branches, and emits one-cycle writeback/branch strobes toward the register file and PC logic.

Parameters:
MEM_TIMEOUT, 15, cycles MEM state waits for mem_ack before aborting with mem_error
CNT_W, 4, width of memory wait counter; MEM_TIMEOUT must be <= 2^CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction fields valid
instr_ready  out  1  sequencer can accept (high only in IDLE)
opcode  in  3  instruction class
funct  in  4  operation within class
alu_carry  in  1  ALU carry out
alu_zero  in  1  ALU zero flag
alu_sign  in  1  ALU sign flag
mem_ack  in  1  memory access complete
alu_op  out  5  ALU operation select
alu_sel  out  1  ALU operand select (1 = constant 1 / inverted b)
mem_read  out  1  level, held in MEM for loads
mem_write  out  1  level, held in MEM for stores
reg_write  out  1  one-cycle writeback strobe
branch_taken  out  1  one-cycle strobe, PC redirect
done  out  1  one-cycle instruction-complete strobe
illegal  out  1  one-cycle strobe with done, undefined opcode/funct
mem_error  out  1  one-cycle strobe with done, memory timeout
busy  out  1  high in any state except IDLE
flag_c, flag_z, flag_s  out  1 each  architectural flag register

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except instr_ready=1; flags 0; wait counter 0. Reset in any state aborts the instruction with no done pulse.
- States: IDLE -> DECODE -> EXEC -> (MEM) -> WB -> IDLE.
- IDLE: instr_valid & instr_ready captures opcode/funct into registers.
- DECODE: decode into registered alu_op/alu_sel/class. Undefined combinations skip to WB with illegal.
- EXEC: alu_op/alu_sel driven for exactly this cycle. Outside EXEC, alu_op=00000 and alu_sel=0.
  - At end of EXEC, flag_z<=alu_zero and flag_s<=alu_sign for every ALU instruction.
  - flag_c<=alu_carry only when alu_op=00001; otherwise flag_c holds.
- Latency: accept at cycle 0, done at cycle 3 for non-memory instructions. Next accept is possible at cycle 4.
- Decode table (opcode, funct -> alu_op/alu_sel):
  - 000 R-type: 0001 add 00001/0; 0010 comp 00101/1; 0011 and 00010/0; 0100 xor 00011/0; 0101 shll 01000/0; 0110 shrl 01010/0; 0111 shra 01011/0. Shift encoding: bit1 = direction (1 = right), bit0 = arithmetic.
  - 001 immediate: 0001 addi 00001/0; 0010 compi 00101/1.
  - 010 memory: 0000 load, 0001 store; both 10101/0, no carry update.
  - 011 branch, alu_op 00000 (pass a): 0000 bz (taken if alu_zero); 0001 bnz; 0010 bltz (alu_sign); 0011 bgez; 0100 bcy (stored flag_c); 0101 bncy.
  - 100 jump: 0000, alu_op 00000, always taken.
  - Everything else: illegal.
- MEM (loads/stores only):
  - mem_read or mem_write held high; counter increments each cycle.
  - mem_ack exits to WB on the same cycle edge.
  - Counter reaching MEM_TIMEOUT without ack exits to WB with mem_error.
  - An ack in the timeout cycle counts as success.
- WB:
  - done=1 for one cycle.
  - reg_write=1 for R-type, immediate and successful load.
  - branch_taken=1 for taken branch or jump.
  - illegal and mem_error suppress reg_write.
- instr_valid outside IDLE is ignored; the source must hold it until accepted.

Decomposition:
- Shared package: state encoding, opcode/funct localparams, ALU op constants (ALU_PASS=00000, ALU_ADD=00001, ALU_ADDNC=00101, ALU_ADDR=10101, ALU_AND=00010, ALU_XOR=00011, ALU_SHLL=01000, ALU_SHRL=01010, ALU_SHRA=01011).
- One combinational sub-module, alu_ctrl_decode: (opcode, funct) -> alu_op, alu_sel, class, illegal. The FSM registers its outputs in DECODE.

Test Plan:
- add (000/0001), ALU returns carry=1 zero=1 sign=0 -> alu_op=00001 in cycle 2 only; done+reg_write in cycle 3; flag_c=1, flag_z=1, flag_s=0.
- comp (000/0010) after that add, carry=0 -> alu_op=00101, alu_sel=1; flag_c stays 1; flag_z/s updated.
- load with mem_ack on 3rd MEM cycle -> mem_read high 3 cycles; done+reg_write at cycle 6; alu_op=10101 in EXEC.
- store, no ack -> mem_write high MEM_TIMEOUT cycles; then done+mem_error, reg_write=0.
- bz with alu_zero=1 -> branch_taken=1; bcy with flag_c=0 -> branch_taken=0, done=1.
- opcode 111 -> done+illegal at cycle 2, no EXEC cycle. rst asserted in EXEC -> next cycle IDLE, flags 0, no done.
